// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of a single shared ALU: accepts one request at a time,
// registers its operands to the ALU, and returns the captured result on the winner's port.
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTL_WIDTH  = 4,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTL_WIDTH-1:0]  req0_ctl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTL_WIDTH-1:0]  req1_ctl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,

    output logic [CTL_WIDTH-1:0]  alu_ctl,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant_valid;
    logic   grant;
    logic   ctl_legal;
    logic   rsp_done;

    // Grant is only offered in IDLE; ties go to the fixed winner or alternate
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant       = FIXED_PRIO ? 1'b0 : ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid && !grant;
    assign req1_ready = grant_valid && grant;

    always_comb begin
        ctl_legal = 1'b0;
        case (alu_ctl)
            CTL_WIDTH'(4'b0000),
            CTL_WIDTH'(4'b0001),
            CTL_WIDTH'(4'b0010),
            CTL_WIDTH'(4'b0110),
            CTL_WIDTH'(4'b0111): ctl_legal = 1'b1;
            default:             ctl_legal = 1'b0;
        endcase
    end

    assign rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_ctl    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_ctl    <= grant ? req1_ctl : req0_ctl;
                        alu_a      <= grant ? req1_a   : req0_a;
                        alu_b      <= grant ? req1_b   : req0_b;
                        owner      <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal codes never expose whatever the ALU produced
                    if (ctl_legal) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                    end else begin
                        rsp_result <= '0;
                        rsp_zero   <= 1'b0;
                        rsp_err    <= 1'b1;
                    end
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus, each driving its own behavioural ALU.
module tb_alu_share_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [CW-1:0] req0_ctl, req1_ctl;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp0_ready, rsp1_ready;

    logic          rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
    logic [DW-1:0] rr_rsp_result, rr_alu_a, rr_alu_b, rr_alu_result;
    logic          rr_rsp_zero, rr_rsp_err, rr_alu_zero, rr_busy;
    logic [CW-1:0] rr_alu_ctl;

    logic          fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic [DW-1:0] fp_rsp_result, fp_alu_a, fp_alu_b, fp_alu_result;
    logic          fp_rsp_zero, fp_rsp_err, fp_alu_zero, fp_busy;
    logic [CW-1:0] fp_alu_ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reference ALU; unknown codes return garbage so forcing to 0 is observable
    function automatic logic [DW-1:0] alu_f(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (c)
            4'b0000: alu_f = a & b;
            4'b0001: alu_f = a | b;
            4'b0010: alu_f = a + b;
            4'b0110: alu_f = a - b;
            4'b0111: alu_f = {63'd0, ($signed(a) < $signed(b))};
            default: alu_f = 64'hDEAD;
        endcase
    endfunction

    assign rr_alu_result = alu_f(rr_alu_ctl, rr_alu_a, rr_alu_b);
    assign rr_alu_zero   = (rr_alu_result == '0);
    assign fp_alu_result = alu_f(fp_alu_ctl, fp_alu_a, fp_alu_b);
    assign fp_alu_zero   = (fp_alu_result == '0);

    alu_share_arbiter #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rr_rsp_result), .rsp_zero(rr_rsp_zero), .rsp_err(rr_rsp_err),
        .alu_ctl(rr_alu_ctl), .alu_a(rr_alu_a), .alu_b(rr_alu_b),
        .alu_result(rr_alu_result), .alu_zero(rr_alu_zero), .busy(rr_busy)
    );

    alu_share_arbiter #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .rsp_err(fp_rsp_err),
        .alu_ctl(fp_alu_ctl), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
        .alu_result(fp_alu_result), .alu_zero(fp_alu_zero), .busy(fp_busy)
    );

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_ctl = '0; req1_ctl = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (rr_busy !== 1'b0 || rr_rsp0_valid !== 1'b0 || rr_rsp1_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b rsp0_valid=%b rsp1_valid=%b expected 0 0 0",
                     rr_busy, rr_rsp0_valid, rr_rsp1_valid);
        end
        n_checks++;
        if (rr_rsp_result !== '0 || rr_rsp_zero !== 1'b0 || rr_rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_rsp: result=%0h zero=%b err=%b expected 0 0 0",
                     rr_rsp_result, rr_rsp_zero, rr_rsp_err);
        end
        n_checks++;
        if (rr_alu_ctl !== '0 || rr_alu_a !== '0 || rr_alu_b !== '0) begin
            n_errors++;
            $display("FAIL reset_alu: ctl=%0h a=%0h b=%0h expected 0 0 0",
                     rr_alu_ctl, rr_alu_a, rr_alu_b);
        end
        n_checks++;
        if (rr_req0_ready !== 1'b0 || rr_req1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: req0_ready=%b req1_ready=%b expected 0 0",
                     rr_req0_ready, rr_req1_ready);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_ctl = 4'b0010; req0_a = 64'd5; req0_b = 64'd7;
        #1;
        n_checks++;
        if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL add_accept: req0_ready=%b req1_ready=%b expected 1 0",
                     rr_req0_ready, rr_req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++;
        if (rr_busy !== 1'b1 || rr_rsp0_valid !== 1'b0 || rr_alu_a !== 64'd5 || rr_alu_b !== 64'd7) begin
            n_errors++;
            $display("FAIL add_exec: busy=%b rsp0_valid=%b alu_a=%0d alu_b=%0d expected 1 0 5 7",
                     rr_busy, rr_rsp0_valid, rr_alu_a, rr_alu_b);
        end
        @(negedge clk);
        n_checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp1_valid !== 1'b0 || rr_rsp_result !== 64'd12 ||
            rr_rsp_zero !== 1'b0 || rr_rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL add_resp: rsp0_valid=%b rsp1_valid=%b result=%0d zero=%b err=%b expected 1 0 12 0 0",
                     rr_rsp0_valid, rr_rsp1_valid, rr_rsp_result, rr_rsp_zero, rr_rsp_err);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        n_checks++;
        if (rr_rsp0_valid !== 1'b0 || rr_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL add_done: rsp0_valid=%b busy=%b expected 0 0", rr_rsp0_valid, rr_busy);
        end
        n_checks++;
        if (rr_alu_a !== 64'd5 || rr_alu_ctl !== 4'b0010) begin
            n_errors++;
            $display("FAIL alu_hold: alu_a=%0d alu_ctl=%0h expected 5 2", rr_alu_a, rr_alu_ctl);
        end
    endtask

    // Round-robin and fixed-priority instances see the same contention
    task automatic test_contention();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_ctl = 4'b0000; req0_a = 64'hF0; req0_b = 64'h3C;
        req1_valid = 1'b1; req1_ctl = 4'b0001; req1_a = 64'h0F; req1_b = 64'h30;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic accept;
            logic port;
            if (c != 0) @(negedge clk);
            #1;
            accept = ((c % 3) == 0);
            port   = ((c / 3) % 2) == 1;
            n_checks++;
            if (rr_req0_ready !== (accept && !port) || rr_req1_ready !== (accept && port)) begin
                n_errors++;
                $display("FAIL rr_grant c=%0d: req0_ready=%b req1_ready=%b expected %b %b",
                         c, rr_req0_ready, rr_req1_ready, accept && !port, accept && port);
            end
            n_checks++;
            if (fp_req0_ready !== accept || fp_req1_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL fp_grant c=%0d: req0_ready=%b req1_ready=%b expected %b 0",
                         c, fp_req0_ready, fp_req1_ready, accept);
            end
            if ((c % 3) == 2) begin
                n_checks++;
                if (rr_rsp0_valid !== !port || rr_rsp1_valid !== port ||
                    rr_rsp_result !== (port ? 64'h3F : 64'h30)) begin
                    n_errors++;
                    $display("FAIL rr_resp c=%0d: rsp0_valid=%b rsp1_valid=%b result=%0h expected %b %b %0h",
                             c, rr_rsp0_valid, rr_rsp1_valid, rr_rsp_result, !port, port,
                             port ? 64'h3F : 64'h30);
                end
                n_checks++;
                if (fp_rsp0_valid !== 1'b1 || fp_rsp1_valid !== 1'b0 || fp_rsp_result !== 64'h30) begin
                    n_errors++;
                    $display("FAIL fp_resp c=%0d: rsp0_valid=%b rsp1_valid=%b result=%0h expected 1 0 30",
                             c, fp_rsp0_valid, fp_rsp1_valid, fp_rsp_result);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_ctl = 4'b0110; req1_a = 64'd9; req1_b = 64'd9;
        #1;
        n_checks++;
        if (rr_req1_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_accept: req1_ready=%b expected 1", rr_req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        // Port 0 arrives while busy and must wait
        req0_valid = 1'b1; req0_ctl = 4'b0111; req0_a = 64'd3; req0_b = 64'd8;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) rsp1_ready = 1'b1;
            #1;
            n_checks++;
            if (rr_rsp1_valid !== 1'b1 || rr_rsp0_valid !== 1'b0 || rr_rsp_result !== '0 ||
                rr_rsp_zero !== 1'b1 || rr_rsp_err !== 1'b0 || rr_req0_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold k=%0d: rsp1_valid=%b rsp0_valid=%b result=%0h zero=%b err=%b req0_ready=%b expected 1 0 0 1 0 0",
                         k, rr_rsp1_valid, rr_rsp0_valid, rr_rsp_result, rr_rsp_zero, rr_rsp_err,
                         rr_req0_ready);
            end
        end
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        n_checks++;
        if (rr_rsp1_valid !== 1'b0 || rr_req0_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: rsp1_valid=%b req0_ready=%b expected 0 1",
                     rr_rsp1_valid, rr_req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp_result !== 64'd1 || rr_rsp_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL waiter_resp: rsp0_valid=%b result=%0h zero=%b expected 1 1 0",
                     rr_rsp0_valid, rr_rsp_result, rr_rsp_zero);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_ctl = 4'b1111; req0_a = 64'd5; req0_b = 64'd5;
        #1;
        n_checks++;
        if (rr_req0_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ill_accept: req0_ready=%b expected 1", rr_req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp_err !== 1'b1 || rr_rsp_result !== '0 || rr_rsp_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL ill_resp: rsp0_valid=%b err=%b result=%0h zero=%b expected 1 1 0 0",
                     rr_rsp0_valid, rr_rsp_err, rr_rsp_result, rr_rsp_zero);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_ctl = 4'b0010; req0_a = 64'd40; req0_b = 64'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (rr_busy !== 1'b0 || rr_rsp0_valid !== 1'b0 || rr_rsp1_valid !== 1'b0 || rr_alu_a !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: busy=%b rsp0_valid=%b rsp1_valid=%b alu_a=%0h expected 0 0 0 0",
                     rr_busy, rr_rsp0_valid, rr_rsp1_valid, rr_alu_a);
        end
        req1_valid = 1'b1; req1_ctl = 4'b0010; req1_a = 64'd100; req1_b = 64'd23;
        #1;
        n_checks++;
        if (rr_req1_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_accept: req1_ready=%b expected 1", rr_req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        n_checks++;
        if (rr_rsp0_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL dropped_op: rsp0_valid=%b expected 0", rr_rsp0_valid);
        end
        @(negedge clk);
        n_checks++;
        if (rr_rsp1_valid !== 1'b1 || rr_rsp0_valid !== 1'b0 || rr_rsp_result !== 64'd123) begin
            n_errors++;
            $display("FAIL post_reset_resp: rsp1_valid=%b rsp0_valid=%b result=%0d expected 1 0 123",
                     rr_rsp1_valid, rr_rsp0_valid, rr_rsp_result);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
